// File: rtl/router_nic_port_pkg.sv
// Shared types and constants for the router NIC port: egress FSM encoding,
// counter width and the default packet width.
package router_nic_port_pkg;

    localparam int PKT_W_DEF = 64;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_SEND = 2'b10
    } eg_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    // Packet counters wrap silently from all-ones back to zero.
    function automatic cnt_t cnt_inc(input cnt_t c);
        return c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/router_nic_port_if.sv
// NIC-side, crossbar-side and status signals of one router NIC port.
// master = the port itself; slave = the NIC/crossbar environment.
interface router_nic_port_if #(
    parameter int PACKET_WIDTH = router_nic_port_pkg::PKT_W_DEF
);
    import router_nic_port_pkg::*;

    logic                    polarity;
    logic                    nic_so;
    logic                    nic_ro;
    logic [PACKET_WIDTH-1:0] nic_do;
    logic                    nic_si;
    logic                    nic_ri;
    logic [PACKET_WIDTH-1:0] nic_di;
    logic                    inj_valid;
    logic                    inj_ready;
    logic [PACKET_WIDTH-1:0] inj_data;
    logic                    ej_valid;
    logic                    ej_ready;
    logic [PACKET_WIDTH-1:0] ej_data;
    cnt_t                    rx_count;
    cnt_t                    tx_count;
    logic                    ovf_err;

    modport master (
        output polarity, nic_ro, nic_si, nic_di,
        output inj_valid, inj_data, ej_ready,
        output rx_count, tx_count, ovf_err,
        input  nic_so, nic_do, nic_ri, inj_ready, ej_valid, ej_data
    );

    modport slave (
        input  polarity, nic_ro, nic_si, nic_di,
        input  inj_valid, inj_data, ej_ready,
        input  rx_count, tx_count, ovf_err,
        output nic_so, nic_do, nic_ri, inj_ready, ej_valid, ej_data
    );

endinterface

// File: rtl/router_nic_port_pkt_slot.sv
// One-entry valid/data holding register; load lands on the next edge, load beats clear.
// No backpressure of its own: the owner decides when load/clear are legal.
module pkt_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_dat,
    input  logic         i_clr,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    // A same-edge load and clear means "drain the old packet, keep the new one".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_load_dat;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule

// File: rtl/router_nic_port.sv
// Router NIC port: one-entry ingress slot (1-cycle capture) and phase-gated egress FSM.
// Ingress drops and flags overflow when full; egress holds its packet until nic_ri on a polarity-0 cycle.
module router_nic_port
    import router_nic_port_pkg::*;
#(
    parameter int PACKET_WIDTH = PKT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    router_nic_port_if.master bus
);

    logic                    r_polarity;
    logic                    r_ovf_err;
    cnt_t                    r_rx_count;
    cnt_t                    r_tx_count;
    logic [PACKET_WIDTH-1:0] r_nic_di;
    eg_state_t               r_state;
    eg_state_t               w_state_nxt;

    logic                    w_ing_vld;
    logic [PACKET_WIDTH-1:0] w_ing_dat;
    logic                    w_ing_drain;
    logic                    w_ing_load;
    logic                    w_ing_ovf;

    logic                    w_eg_vld;
    logic [PACKET_WIDTH-1:0] w_eg_dat;
    logic                    w_eg_load;
    logic                    w_eg_send;
    logic                    w_ej_ready;
    logic                    w_nic_si;
    logic                    w_tx_inc;

    // Ingress: a drain on the same edge frees the slot for the arriving packet.
    assign w_ing_drain = w_ing_vld & bus.inj_ready;
    assign w_ing_load  = bus.nic_so & (~w_ing_vld | w_ing_drain);
    assign w_ing_ovf   = bus.nic_so & w_ing_vld & ~w_ing_drain;

    pkt_slot #(.W(PACKET_WIDTH)) u_ing_slot (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_ing_load),
        .i_load_dat (bus.nic_do),
        .i_clr      (w_ing_drain),
        .o_vld      (w_ing_vld),
        .o_dat      (w_ing_dat)
    );

    pkt_slot #(.W(PACKET_WIDTH)) u_eg_slot (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_eg_load),
        .i_load_dat (bus.ej_data),
        .i_clr      (w_eg_send),
        .o_vld      (w_eg_vld),
        .o_dat      (w_eg_dat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_polarity <= 1'b0;
            r_ovf_err  <= 1'b0;
            r_rx_count <= '0;
        end else begin
            r_polarity <= ~r_polarity;
            if (w_ing_ovf) begin
                r_ovf_err <= 1'b1;
            end
            if (w_ing_load) begin
                r_rx_count <= cnt_inc(r_rx_count);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_nic_di   <= '0;
            r_tx_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_eg_send) begin
                r_nic_di <= w_eg_dat;
            end
            if (w_tx_inc) begin
                r_tx_count <= cnt_inc(r_tx_count);
            end
        end
    end

    // Launch only while polarity reads 0, so the pulse lands in the NIC's transmit phase.
    always_comb begin
        w_state_nxt = r_state;
        w_ej_ready  = 1'b0;
        w_eg_load   = 1'b0;
        w_eg_send   = 1'b0;
        w_nic_si    = 1'b0;
        w_tx_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ej_ready = reset;
                if (bus.ej_valid) begin
                    w_eg_load   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_eg_vld && bus.nic_ri && !r_polarity) begin
                    w_eg_send   = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_nic_si    = 1'b1;
                w_tx_inc    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.polarity  = r_polarity;
    assign bus.nic_ro    = ~w_ing_vld;
    assign bus.nic_si    = w_nic_si;
    assign bus.nic_di    = r_nic_di;
    assign bus.inj_valid = w_ing_vld;
    assign bus.inj_data  = w_ing_dat;
    assign bus.ej_ready  = w_ej_ready;
    assign bus.rx_count  = r_rx_count;
    assign bus.tx_count  = r_tx_count;
    assign bus.ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_router_nic_port.sv
// Bench for router_nic_port: directed scenarios plus randomized traffic against a packet-level model.
module tb_router_nic_port;
    import router_nic_port_pkg::*;

    localparam int W = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    router_nic_port_if #(.PACKET_WIDTH(W)) bus ();

    router_nic_port #(.PACKET_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Packet-level reference state.
    logic         m_pol, m_full, m_ovf, m_pend, m_send;
    logic [W-1:0] m_data, m_eg_data, m_di;
    logic [15:0]  m_rx, m_tx;

    task automatic model_reset();
        m_pol = 0; m_full = 0; m_ovf = 0; m_pend = 0; m_send = 0;
        m_data = '0; m_eg_data = '0; m_di = '0; m_rx = '0; m_tx = '0;
    endtask

    task automatic idle_inputs();
        bus.nic_so = 0; bus.nic_do = '0; bus.inj_ready = 0;
        bus.ej_valid = 0; bus.ej_data = '0; bus.nic_ri = 0;
    endtask

    // One clock: inputs are stable before the edge; model follows the rules at the edge.
    task automatic step();
        logic so, ir, ev, ri, drain;
        logic [W-1:0] d, ed;
        so = bus.nic_so; ir = bus.inj_ready; d = bus.nic_do;
        ev = bus.ej_valid; ed = bus.ej_data; ri = bus.nic_ri;
        @(posedge clk);
        drain = m_full && ir;
        if (so && (!m_full || drain)) begin
            m_full = 1; m_data = d; m_rx = m_rx + 16'd1;
        end else if (so) begin
            m_ovf = 1;
        end else if (drain) begin
            m_full = 0;
        end
        if (m_send) begin
            m_send = 0; m_tx = m_tx + 16'd1;
        end else if (m_pend) begin
            if (ri && !m_pol) begin
                m_pend = 0; m_send = 1; m_di = m_eg_data;
            end
        end else if (ev) begin
            m_pend = 1; m_eg_data = ed;
        end
        m_pol = !m_pol;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 0;
        model_reset();
        @(negedge clk);
        reset = 1;
        #1;
    endtask

    task automatic send_pkt(input logic [W-1:0] d);
        bus.ej_valid = 1; bus.ej_data = d; bus.nic_ri = 1;
        step();
        bus.ej_valid = 0;
        for (int k = 0; k < 8 && (m_pend || m_send); k++) step();
        bus.nic_ri = 0;
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        @(negedge clk);
        idle_inputs();
        reset = 0;
        model_reset();
        @(posedge clk); #1;
        flags = {bus.polarity, bus.nic_ro, bus.nic_si, bus.inj_valid, bus.ej_ready, bus.ovf_err};
        n_cmp++;
        if (flags !== 6'b010000) begin
            n_err++; $display("FAIL reset_flags: got %b want 010000", flags);
        end
        n_cmp++;
        if (bus.nic_di !== '0 || bus.inj_data !== '0) begin
            n_err++; $display("FAIL reset_data: nic_di %h inj_data %h want 0", bus.nic_di, bus.inj_data);
        end
        n_cmp++;
        if (bus.rx_count !== 16'd0 || bus.tx_count !== 16'd0) begin
            n_err++; $display("FAIL reset_counts: rx %0d tx %0d want 0", bus.rx_count, bus.tx_count);
        end
        @(negedge clk);
        reset = 1;
        #1;
        n_cmp++;
        if (bus.ej_ready !== 1'b1) begin
            n_err++; $display("FAIL release_ej_ready: got %b want 1", bus.ej_ready);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.polarity !== 1'(i % 2)) begin
                n_err++; $display("FAIL polarity_seq[%0d]: got %b want %0d", i, bus.polarity, i % 2);
            end
            step();
        end
        n_cmp++;
        if (bus.nic_ro !== 1'b1 || bus.rx_count !== 16'd0 || bus.tx_count !== 16'd0) begin
            n_err++; $display("FAIL idle_after_release: nic_ro %b rx %0d tx %0d want 1/0/0",
                              bus.nic_ro, bus.rx_count, bus.tx_count);
        end
    endtask

    task automatic test_ingress_overflow();
        do_reset();
        bus.nic_so = 1; bus.nic_do = 64'hDEAD_BEEF_0000_0001;
        step();
        bus.nic_so = 0;
        n_cmp++;
        if (bus.inj_valid !== 1'b1 || bus.inj_data !== 64'hDEAD_BEEF_0000_0001) begin
            n_err++; $display("FAIL ing_capture: valid %b data %h want 1 deadbeef00000001", bus.inj_valid, bus.inj_data);
        end
        n_cmp++;
        if (bus.nic_ro !== 1'b0 || bus.rx_count !== 16'd1 || bus.ovf_err !== 1'b0) begin
            n_err++; $display("FAIL ing_status: nic_ro %b rx %0d ovf %b want 0/1/0", bus.nic_ro, bus.rx_count, bus.ovf_err);
        end
        bus.nic_so = 1; bus.nic_do = 64'h1234_5678_9ABC_DEF0;
        step();
        bus.nic_so = 0;
        n_cmp++;
        if (bus.ovf_err !== 1'b1 || bus.inj_data !== 64'hDEAD_BEEF_0000_0001 || bus.rx_count !== 16'd1) begin
            n_err++; $display("FAIL ing_overflow: ovf %b data %h rx %0d want 1 deadbeef00000001 1",
                              bus.ovf_err, bus.inj_data, bus.rx_count);
        end
        bus.inj_ready = 1;
        step();
        bus.inj_ready = 0;
        step();
        n_cmp++;
        if (bus.inj_valid !== 1'b0 || bus.nic_ro !== 1'b1 || bus.ovf_err !== 1'b1) begin
            n_err++; $display("FAIL ing_drain: valid %b nic_ro %b ovf %b want 0/1/1", bus.inj_valid, bus.nic_ro, bus.ovf_err);
        end
    endtask

    task automatic test_drain_and_capture();
        do_reset();
        bus.nic_so = 1; bus.nic_do = 64'h1;
        step();
        bus.nic_do = 64'h2; bus.inj_ready = 1;
        step();
        bus.nic_so = 0; bus.inj_ready = 0;
        n_cmp++;
        if (bus.inj_valid !== 1'b1 || bus.inj_data !== 64'h2) begin
            n_err++; $display("FAIL same_cycle_capture: valid %b data %h want 1 2", bus.inj_valid, bus.inj_data);
        end
        n_cmp++;
        if (bus.ovf_err !== 1'b0 || bus.rx_count !== 16'd2) begin
            n_err++; $display("FAIL same_cycle_status: ovf %b rx %0d want 0 2", bus.ovf_err, bus.rx_count);
        end
    endtask

    task automatic test_egress_basic();
        int           pulses;
        logic         p, launch_pol;
        logic [W-1:0] di;
        do_reset();
        pulses = 0; launch_pol = 1; di = '0;
        bus.ej_valid = 1; bus.ej_data = 64'hCAFE; bus.nic_ri = 1;
        for (int k = 0; k < 8; k++) begin
            p = bus.polarity;
            step();
            bus.ej_valid = 0;
            if (bus.nic_si) begin
                pulses++; launch_pol = p; di = bus.nic_di;
            end
        end
        bus.nic_ri = 0;
        n_cmp++;
        if (pulses != 1 || launch_pol !== 1'b0) begin
            n_err++; $display("FAIL eg_pulse: pulses %0d launch_pol %b want 1 0", pulses, launch_pol);
        end
        n_cmp++;
        if (di !== 64'hCAFE || bus.tx_count !== 16'd1) begin
            n_err++; $display("FAIL eg_data: nic_di %h tx %0d want cafe 1", di, bus.tx_count);
        end
    endtask

    task automatic test_egress_hold();
        logic [W-1:0] d;
        int           hi, waited;
        logic         p, found, launch_pol;
        do_reset();
        d = {$urandom, $urandom};
        bus.ej_valid = 1; bus.ej_data = d; bus.nic_ri = 0;
        step();
        bus.ej_valid = 0;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.nic_si || bus.ej_ready) hi++;
        end
        n_cmp++;
        if (hi != 0) begin
            n_err++; $display("FAIL hold_quiet: %0d busy-violating cycles want 0", hi);
        end
        bus.nic_ri = 1;
        found = 0; waited = 0; launch_pol = 1;
        for (int k = 0; k < 4 && !found; k++) begin
            p = bus.polarity;
            step();
            waited++;
            if (bus.nic_si) begin
                found = 1; launch_pol = p;
            end
        end
        n_cmp++;
        if (!found || launch_pol !== 1'b0 || waited > 2 || bus.nic_di !== d) begin
            n_err++; $display("FAIL hold_release: found %b pol %b waited %0d di %h want 1 0 <=2 %h",
                              found, launch_pol, waited, bus.nic_di, d);
        end
        step();
        bus.nic_ri = 0;
        n_cmp++;
        if (bus.tx_count !== 16'd1 || bus.nic_si !== 1'b0) begin
            n_err++; $display("FAIL hold_done: tx %0d si %b want 1 0", bus.tx_count, bus.nic_si);
        end
    endtask

    task automatic test_random();
        logic prev_si;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                bus.nic_so    = ($urandom_range(0, 99) < 35);
                bus.nic_do    = {$urandom, $urandom};
                bus.inj_ready = ($urandom_range(0, 99) < 70);
                bus.ej_valid  = ($urandom_range(0, 99) < 50);
                bus.ej_data   = {$urandom, $urandom};
                bus.nic_ri    = ($urandom_range(0, 99) < 70);
                prev_si = bus.nic_si;
                step();
                n_cmp++;
                if (bus.inj_valid !== m_full || bus.nic_ro !== !m_full || bus.inj_data !== m_data) begin
                    n_err++; $display("FAIL rnd_ingress c%0d: valid %b ro %b data %h want %b %b %h",
                                      c, bus.inj_valid, bus.nic_ro, bus.inj_data, m_full, !m_full, m_data);
                end
                n_cmp++;
                if (bus.rx_count !== m_rx || bus.ovf_err !== m_ovf) begin
                    n_err++; $display("FAIL rnd_rx c%0d: rx %0d ovf %b want %0d %b", c, bus.rx_count, bus.ovf_err, m_rx, m_ovf);
                end
                n_cmp++;
                if (bus.nic_si !== m_send || bus.nic_di !== m_di || bus.ej_ready !== !(m_pend || m_send)) begin
                    n_err++; $display("FAIL rnd_egress c%0d: si %b di %h ej_ready %b want %b %h %b",
                                      c, bus.nic_si, bus.nic_di, bus.ej_ready, m_send, m_di, !(m_pend || m_send));
                end
                n_cmp++;
                if (bus.tx_count !== m_tx || bus.polarity !== m_pol || (prev_si && bus.nic_si)) begin
                    n_err++; $display("FAIL rnd_tx c%0d: tx %0d pol %b back2back %b want %0d %b 0",
                                      c, bus.tx_count, bus.polarity, prev_si && bus.nic_si, m_tx, m_pol);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap_and_reset();
        int hi;
        do_reset();
        // Stand-in for 65534 earlier deliveries.
        force dut.r_tx_count = 16'hFFFE;
        #1;
        release dut.r_tx_count;
        m_tx = 16'hFFFE;
        send_pkt(64'h55);
        n_cmp++;
        if (bus.tx_count !== 16'hFFFF || bus.tx_count !== m_tx) begin
            n_err++; $display("FAIL tx_65535: got %h want ffff", bus.tx_count);
        end
        send_pkt(64'h66);
        n_cmp++;
        if (bus.tx_count !== 16'h0000) begin
            n_err++; $display("FAIL tx_wrap: got %h want 0000", bus.tx_count);
        end
        bus.ej_valid = 1; bus.ej_data = 64'h77; bus.nic_ri = 0;
        bus.nic_so = 1; bus.nic_do = 64'h88;
        step();
        bus.ej_valid = 0; bus.nic_so = 0;
        step();
        n_cmp++;
        if (bus.ej_ready !== 1'b0 || bus.inj_valid !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_busy: ej_ready %b inj_valid %b want 0 1", bus.ej_ready, bus.inj_valid);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
        #2;
        n_cmp++;
        if ({bus.polarity, bus.nic_ro, bus.nic_si, bus.inj_valid, bus.ej_ready, bus.ovf_err} !== 6'b010000
            || bus.nic_di !== '0 || bus.inj_data !== '0 || bus.rx_count !== 16'd0 || bus.tx_count !== 16'd0) begin
            n_err++; $display("FAIL mid_reset: pol %b ro %b si %b iv %b er %b ovf %b di %h id %h rx %0d tx %0d want reset values",
                              bus.polarity, bus.nic_ro, bus.nic_si, bus.inj_valid, bus.ej_ready, bus.ovf_err,
                              bus.nic_di, bus.inj_data, bus.rx_count, bus.tx_count);
        end
        @(negedge clk);
        reset = 1;
        bus.nic_ri = 1;
        #1;
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.nic_si) hi++;
        end
        bus.nic_ri = 0;
        n_cmp++;
        if (hi != 0 || bus.tx_count !== 16'd0 || bus.ej_ready !== 1'b1) begin
            n_err++; $display("FAIL packet_lost: pulses %0d tx %0d ej_ready %b want 0 0 1", hi, bus.tx_count, bus.ej_ready);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_ingress_overflow();
        test_drain_and_capture();
        test_egress_basic();
        test_egress_hold();
        test_random();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/router_nic_port.md
ROUTER_NIC_PORT -- requirements
Module: router_nic_port

Interface
REQ-001 Parameter PACKET_WIDTH, default 64, sets the packet width in bits for every data port and buffer.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 resets all state immediately.
REQ-004 polarity  output  1  link phase; NIC transmits only when it reads 1.
REQ-005 nic_so  input  1  NIC-to-router packet valid.
REQ-006 nic_ro  output  1  router ingress buffer empty, ready for the NIC.
REQ-007 nic_do  input  PACKET_WIDTH  NIC-to-router packet data.
REQ-008 nic_si  output  1  router-to-NIC packet valid, one-cycle pulse.
REQ-009 nic_ri  input  1  NIC input buffer has space.
REQ-010 nic_di  output  PACKET_WIDTH  router-to-NIC packet data.
REQ-011 inj_valid / inj_ready / inj_data  output / input / output  1 / 1 / PACKET_WIDTH  ingress packet toward the crossbar.
REQ-012 ej_valid / ej_ready / ej_data  input / output / input  1 / 1 / PACKET_WIDTH  crossbar packet toward the NIC.
REQ-013 rx_count / tx_count  output  16 each  packets accepted from the NIC / delivered to the NIC.
REQ-014 ovf_err  output  1  sticky ingress overflow flag.

Function
REQ-015 The polarity register toggles every cycle.
REQ-016 Ingress path: one-entry buffer. nic_ro is driven combinationally as the inverse of the buffer-full bit.
REQ-017 nic_so=1 with the buffer empty: capture nic_do, set full, and increment rx_count (16-bit, wraps 0xFFFF->0).
REQ-018 nic_so=1 with the buffer full: discard nic_do, leave the buffer unchanged, and set ovf_err until reset.
REQ-019 inj_valid equals buffer full and inj_data equals the buffer contents.
REQ-020 The ingress buffer clears on an edge where inj_valid and inj_ready are both 1.
REQ-021 Simultaneous drain and nic_so in the same cycle: drain completes, the new packet is captured, the buffer stays full, and no overflow is flagged.
REQ-022 Egress path: one-entry buffer driven by a 3-state FSM: IDLE, HOLD, SEND.
REQ-023 ej_ready = 1 only in IDLE.
REQ-024 IDLE: if ej_valid, capture ej_data and go to HOLD.
REQ-025 HOLD: if nic_ri=1 and polarity=0, register nic_di = buffer, set nic_si=1, and go to SEND.
REQ-026 HOLD: otherwise remain in HOLD, with nic_si=0 and nic_di held.
REQ-027 SEND: lasts one cycle with nic_si=1; the next edge drops nic_si to 0, increments tx_count (wraps), and goes to IDLE.
REQ-028 Result of the egress rules: nic_si is never high for two consecutive cycles, and NIC deliveries are at least 3 cycles apart.
REQ-029 nic_di holds its last value when nic_si=0.
REQ-030 Ingress and egress operate independently; simultaneous activity on both paths is legal.

Reset
REQ-031 While reset=0, the block forces these values:
- polarity=0, nic_ro=1, nic_si=0, nic_di=0
- inj_valid=0, inj_data=0, ej_ready=0
- FSM=IDLE, both buffers empty and zeroed
- rx_count=0, tx_count=0, ovf_err=0
REQ-032 ej_ready becomes 1 one combinational delay after reset deasserts (FSM is in IDLE).
REQ-033 Reset asserted mid-transfer aborts the transfer, and the pending packet is lost.

Structure
REQ-034 A shared package holds:
- PACKET_WIDTH default
- egress FSM state encoding (IDLE=2'b00, HOLD=2'b01, SEND=2'b10)
- counter width constant (16)
REQ-035 The one-entry valid/data register is implemented as sub-module pkt_slot and instantiated for ingress and egress.
REQ-036 The remaining logic (polarity, FSM, counters) is flat in router_nic_port.

Verification
REQ-037 The bench covers these directed scenarios:
- Reset release: polarity toggles 0,1,0,1; nic_ro=1; ej_ready=1; counters 0.
- NIC sends 64'hDEAD_BEEF_0000_0001 with inj_ready=0: inj_valid=1 with that data, nic_ro=0, rx_count=1. Second nic_so: ovf_err=1, inj_data unchanged.
- inj_ready=1 in the same cycle as nic_so carrying 64'h2: buffer holds 64'h2, ovf_err stays 0, rx_count increments.
- ej_valid with 64'hCAFE and nic_ri=1: exactly one nic_si pulse, on a polarity=0 cycle, with nic_di=64'hCAFE; tx_count=1.
- ej_valid with nic_ri=0 for 10 cycles, then 1: FSM holds in HOLD, then sends on the next polarity=0 cycle.
- reset=0 pulse while in HOLD, plus tx_count preloaded via 65535 sends: all outputs return to reset values. Wrap check: 65536th send gives tx_count=0.
